// File: rtl/lhn_tag_cam_sa_if.sv
// Bus between the cache controller (master) and the set-associative tag CAM (slave).
interface lhn_tag_cam_sa_if #(
    parameter int TAG_W     = 8,
    parameter int SETS_LOG2 = 3,
    parameter int WAYS_LOG2 = 1
);
    localparam int WAYS = 2 ** WAYS_LOG2;

    logic                 we_n;
    logic [SETS_LOG2-1:0] wr_set;
    logic [WAYS_LOG2-1:0] wr_way;
    logic [TAG_W-1:0]     wr_tag;
    logic                 inv_n;
    logic                 lk_n;
    logic [SETS_LOG2-1:0] lk_set;
    logic [TAG_W-1:0]     lk_tag;
    logic                 lk_vld;
    logic [WAYS-1:0]      mbits;
    logic                 hit;
    logic [WAYS_LOG2-1:0] hit_way;
    logic [WAYS_LOG2-1:0] victim_way;
    logic                 rd_n;
    logic [TAG_W-1:0]     dout;
    logic                 dout_v;
    logic                 flush_n;
    logic                 busy;

    modport master (
        output we_n, wr_set, wr_way, wr_tag, inv_n,
        output lk_n, lk_set, lk_tag, rd_n, flush_n,
        input  lk_vld, mbits, hit, hit_way, victim_way, dout, dout_v, busy
    );

    modport slave (
        input  we_n, wr_set, wr_way, wr_tag, inv_n,
        input  lk_n, lk_set, lk_tag, rd_n, flush_n,
        output lk_vld, mbits, hit, hit_way, victim_way, dout, dout_v, busy
    );
endinterface

// File: rtl/lhn_tag_cam_sa.sv
// N-way set-associative tag CAM: registered lookup, per-set round-robin victim,
// sequential flush. States: ST_IDLE | accepts write/invalidate/lookup/flush ; ST_FLUSH | clears one set per cycle
module lhn_tag_cam_sa #(
    parameter int TAG_W     = 8,
    parameter int SETS_LOG2 = 3,
    parameter int WAYS_LOG2 = 1
) (
    input logic             clk,
    input logic             rst_n,
    lhn_tag_cam_sa_if.slave cam
);
    localparam int SETS = 2 ** SETS_LOG2;
    localparam int WAYS = 2 ** WAYS_LOG2;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    state_t                          state_q, state_d;
    logic [SETS_LOG2-1:0]            cnt_q, cnt_d;
    logic [TAG_W-1:0]                tag_q [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
    logic [SETS-1:0][WAYS_LOG2-1:0]  rr_q, rr_d;

    logic                 lk_vld_q, lk_vld_d;
    logic [WAYS-1:0]      mbits_q, mbits_d;
    logic                 hit_q, hit_d;
    logic [WAYS_LOG2-1:0] hit_way_q, hit_way_d;
    logic [WAYS_LOG2-1:0] victim_q, victim_d;

    logic idle, inv_en, wr_en, lk_en, rd_en;

    assign idle   = (state_q == ST_IDLE);
    assign inv_en = idle && !cam.inv_n;
    // Invalidate wins over a simultaneous write to the same entry.
    assign wr_en  = idle && !cam.we_n && cam.inv_n;
    assign lk_en  = idle && !cam.lk_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (!cam.flush_n) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
                if (inv_en) begin
                    valid_d[cam.wr_set][cam.wr_way] = 1'b0;
                end else if (wr_en) begin
                    valid_d[cam.wr_set][cam.wr_way] = 1'b1;
                    if (cam.wr_way == rr_q[cam.wr_set])
                        rr_d[cam.wr_set] = rr_q[cam.wr_set] + 1'b1;
                end
            end
            ST_FLUSH: begin
                valid_d[cnt_q] = '0;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == SETS_LOG2'(SETS - 1))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lk_vld_d  = lk_en;
        mbits_d   = mbits_q;
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        victim_d  = victim_q;
        if (lk_en) begin
            for (int w = 0; w < WAYS; w++)
                mbits_d[w] = valid_q[cam.lk_set][w] && (tag_q[cam.lk_set][w] == cam.lk_tag);
            hit_d = |mbits_d;
            // Scan high-to-low so the lowest matching / invalid way is the one kept.
            hit_way_d = '0;
            victim_d  = rr_q[cam.lk_set];
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (mbits_d[w])
                    hit_way_d = WAYS_LOG2'(w);
                if (!valid_q[cam.lk_set][w])
                    victim_d = WAYS_LOG2'(w);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            valid_q   <= '0;
            rr_q      <= '0;
            lk_vld_q  <= 1'b0;
            mbits_q   <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            lk_vld_q  <= lk_vld_d;
            mbits_q   <= mbits_d;
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            victim_q  <= victim_d;
        end
    end

    // Tag storage carries no reset; the valid bits qualify every use of it.
    always_ff @(posedge clk) begin
        if (wr_en)
            tag_q[cam.wr_set][cam.wr_way] <= cam.wr_tag;
    end

    assign rd_en          = !cam.rd_n && rst_n;
    assign cam.dout       = rd_en ? tag_q[cam.wr_set][cam.wr_way] : '0;
    assign cam.dout_v     = rd_en && valid_q[cam.wr_set][cam.wr_way];
    assign cam.lk_vld     = lk_vld_q;
    assign cam.mbits      = mbits_q;
    assign cam.hit        = hit_q;
    assign cam.hit_way    = hit_way_q;
    assign cam.victim_way = victim_q;
    assign cam.busy       = (state_q == ST_FLUSH);
endmodule

// File: doc/lhn_tag_cam_sa.md
Name: lhn_tag_cam_sa

Overview:
- Parametrised, clocked successor to the lab's 2-way tag CAM.
- N-way set-associative tag store with per-entry valid bits and a registered lookup producing per-way match bits, hit flag and encoded hit way.
- Per-set round-robin victim selection and a multi-cycle flush state machine.
- Sits beside the cache data array; the cache controller writes tags on block fill and looks up on every access.

Parameters:
TAG_W, 8, tag width in bits
SETS_LOG2, 3, log2 of set count (default 8 sets)
WAYS_LOG2, 1, log2 of associativity (default 2-way); WAYS = 2**WAYS_LOG2

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
we_n  in  1  active-low tag write strobe, sampled on clk
wr_set  in  SETS_LOG2  set index for write
wr_way  in  WAYS_LOG2  way index for write
wr_tag  in  TAG_W  tag written; entry becomes valid
inv_n  in  1  active-low single-entry invalidate at wr_set/wr_way
lk_n  in  1  active-low lookup request
lk_set  in  SETS_LOG2  set index for lookup
lk_tag  in  TAG_W  argument tag compared against the set
lk_vld  out  1  lookup result valid, 1 cycle after accepted request
mbits  out  WAYS  per-way match (valid AND tag equal)
hit  out  1  OR of mbits
hit_way  out  WAYS_LOG2  lowest-index matching way; 0 when no hit
victim_way  out  WAYS_LOG2  suggested fill way for lk_set
rd_n  in  1  active-low diagnostic read at wr_set/wr_way
dout  out  TAG_W  diagnostic tag; 0 when not reading
dout_v  out  1  valid bit of the read entry
flush_n  in  1  active-low flush request (level, sampled in IDLE)
busy  out  1  high while flushing

Behaviour:
- Reset (async, rst_n=0): all valid bits, round-robin pointers, lk_vld, mbits, hit, hit_way, victim_way, dout, dout_v and busy go 0; FSM to IDLE. Tag storage is not reset. Reset mid-flush aborts the flush; everything is still invalid.
- FSM states:
  - IDLE: flush_n=0 -> FLUSH with flush counter=0, busy=1 from the next cycle.
  - FLUSH: clears valid bits of set[counter] each cycle and increments the counter; after set 2**SETS_LOG2-1 -> IDLE, busy=0. Flush takes exactly 2**SETS_LOG2 cycles.
  - In FLUSH, we_n, inv_n and lk_n are ignored: no state change, lk_vld stays 0.
- Write: in IDLE with we_n=0, store wr_tag and set valid at the next edge.
  - If wr_way equals the set's rr pointer, the pointer increments mod WAYS.
  - we_n and inv_n both low on the same entry: invalidate wins.
- Lookup: in IDLE with lk_n=0, compare lk_tag against all WAYS entries of lk_set. Results are registered, so lk_vld, mbits, hit and hit_way appear 1 cycle later.
  - lk_vld=1 for exactly one cycle per request; back-to-back requests are allowed at 1 per cycle.
  - Outputs hold their last values when lk_vld=0.
- Same-cycle write and lookup on the same set: lookup sees pre-write contents (read-before-write).
- Multiple matching ways (duplicate tags): all corresponding mbits set; hit_way is the lowest index.
- victim_way, registered with the lookup result:
  - lowest-index invalid way of lk_set if any;
  - otherwise that set's rr pointer.
- Diagnostic read: combinational. rd_n=0 drives dout/dout_v from wr_set/wr_way; otherwise both are 0. It is allowed during FLUSH.
- Index inputs are full-width, so there are no out-of-range cases; the rr pointer wraps from WAYS-1 to 0.

Test Plan:
- Reset then lookup set 3 tag 0x5A -> lk_vld=1 next cycle, mbits=00, hit=0, victim_way=0.
- Write set 2 way 1 tag 0xA7; lookup set 2 tag 0xA7 -> mbits=10, hit=1, hit_way=1; lookup set 3 tag 0xA7 -> hit=0.
- Write 0x11 to set 5 ways 0 and 1 -> mbits=11, hit_way=0; inv_n on way 0, lookup -> mbits=10, hit_way=1.
- Set 4 fully written way 0 then way 1 -> victim_way toggles 0,1,0 across successive fills (rr wrap).
- Fill all 16 entries, pulse flush_n -> busy high exactly 8 cycles; a lookup mid-flush gives no lk_vld; afterwards every lookup misses and dout_v=0.
- Assert rst_n=0 asynchronously mid-flush and mid-lookup -> busy, lk_vld and hit drop immediately; a post-reset lookup misses.
